// File: rtl/mem_access.sv
// mem_access: RV32 memory-access stage. Holds the M pipeline register, runs
// loads/stores over a req/ack data bus with lane steering and load extension,
// stalls while the bus is busy, and flags illegal accesses and bus timeouts.
module mem_access #(
  parameter int unsigned MAX_WAIT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] alu_result_e_i,
  input  logic [31:0] write_data_e_i,
  input  logic [4:0]  rd_e_i,
  input  logic [31:0] pc_plus_4_e_i,
  input  logic        reg_write_e_i,
  input  logic        mem_read_e_i,
  input  logic        mem_write_e_i,
  input  logic [2:0]  funct3_e_i,
  output logic [31:0] alu_result_m_o,
  output logic [4:0]  rd_m_o,
  output logic        reg_write_m_o,
  output logic [31:0] pc_plus_4_m_o,
  output logic [31:0] read_data_m_o,
  output logic        mem_busy_o,
  output logic        misaligned_o,
  output logic        timeout_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i
);

  localparam int unsigned CNT_W = (MAX_WAIT_CYCLES > 1) ? $clog2(MAX_WAIT_CYCLES + 1) : 1;
  // wait_cnt holds the number of request cycles already spent before the current one
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;

  logic [31:0] write_data_m;
  logic        reg_write_m;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [2:0]  funct3_m;

  logic        mem_op, f3_ok, aligned, legal, access, illegal;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // M pipeline register: advances whenever the stage is not stalled
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      alu_result_m_o <= '0;
      write_data_m   <= '0;
      rd_m_o         <= '0;
      pc_plus_4_m_o  <= '0;
      reg_write_m    <= 1'b0;
      mem_read_m     <= 1'b0;
      mem_write_m    <= 1'b0;
      funct3_m       <= '0;
    end else if (!mem_busy_o) begin
      alu_result_m_o <= alu_result_e_i;
      write_data_m   <= write_data_e_i;
      rd_m_o         <= rd_e_i;
      pc_plus_4_m_o  <= pc_plus_4_e_i;
      reg_write_m    <= reg_write_e_i;
      mem_read_m     <= mem_read_e_i;
      mem_write_m    <= mem_write_e_i;
      funct3_m       <= funct3_e_i;
    end
  end

  // Access legality: width/sign code and natural alignment
  always_comb begin
    mem_op = mem_read_m | mem_write_m;
    case (funct3_m)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~mem_write_m;
      default:                f3_ok = 1'b0;
    endcase
    case (funct3_m[1:0])
      2'b01:   aligned = ~alu_result_m_o[0];
      2'b10:   aligned = (alu_result_m_o[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    legal   = f3_ok & aligned;
    access  = mem_op & legal;
    illegal = mem_op & ~legal;
  end

  // Store lane steering and load byte/half extraction
  always_comb begin
    case (funct3_m[1:0])
      2'b00: begin
        lane_be    = 4'(4'b0001 << alu_result_m_o[1:0]);
        lane_wdata = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        lane_be    = alu_result_m_o[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{write_data_m[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = write_data_m;
      end
    endcase
    case (alu_result_m_o[1:0])
      2'b00:   ld_byte = dmem_rdata_i[7:0];
      2'b01:   ld_byte = dmem_rdata_i[15:8];
      2'b10:   ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = alu_result_m_o[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_m)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  // Bus FSM state and wait counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  // Bus FSM next state, request and timeout
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    dmem_req_o = 1'b0;
    timeout_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        dmem_req_o = access;
        if (access && !dmem_ack_i) begin
          if (CNT_LAST == '0) begin
            state_n = ST_FAULT;
          end else begin
            state_n    = ST_WAIT;
            wait_cnt_n = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) begin
          state_n    = ST_IDLE;
          wait_cnt_n = '0;
        end else if (wait_cnt == CNT_LAST) begin
          state_n    = ST_FAULT;
          wait_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end
      ST_FAULT: begin
        timeout_o = 1'b1;
        state_n   = ST_IDLE;
      end
      default: begin
        state_n    = ST_IDLE;
        wait_cnt_n = '0;
      end
    endcase
  end

  // Bus side outputs, stall and writeback qualification
  always_comb begin
    mem_busy_o    = dmem_req_o & ~dmem_ack_i;
    misaligned_o  = illegal;
    dmem_we_o     = dmem_req_o & mem_write_m;
    dmem_addr_o   = {alu_result_m_o[31:2], 2'b00};
    dmem_be_o     = dmem_req_o ? lane_be : 4'b0000;
    dmem_wdata_o  = lane_wdata;
    read_data_m_o = (dmem_req_o && dmem_ack_i) ? ld_ext : 32'd0;
    reg_write_m_o = reg_write_m & ~illegal & (state != ST_FAULT);
  end

endmodule
